// File: rtl/led_scanner.sv
// LED scanner: one lit LED moves across NUM_LED outputs, each output driven by per-LED PWM.
// Define LED_SCANNER_FADE_EN to let deselected LEDs decay gradually instead of going dark at once.
module led_scanner #(
  parameter int NUM_LED      = 8,
  parameter int PWM_BITS     = 5,
  parameter int PWM_DIV_BITS = 10,
  parameter int STEP_BITS    = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [2:0]                 rate,
  output logic [NUM_LED-1:0]         led,
  output logic [$clog2(NUM_LED)-1:0] pos,
  output logic                       step
);

  localparam int POS_W = $clog2(NUM_LED);
  localparam logic [POS_W-1:0]        POS_ZERO    = {POS_W{1'b0}};
  localparam logic [POS_W-1:0]        POS_ONE     = POS_W'(1'b1);
  localparam logic [POS_W-1:0]        POS_LAST    = POS_W'(NUM_LED - 1);
  localparam logic [PWM_BITS-1:0]     LEVEL_MAX   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0]     LEVEL_ZERO  = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0]     TICK_ONE    = PWM_BITS'(1'b1);
  localparam logic [PWM_DIV_BITS-1:0] PRESC_ZERO  = {PWM_DIV_BITS{1'b0}};
  localparam logic [PWM_DIV_BITS-1:0] PRESC_ONE   = PWM_DIV_BITS'(1'b1);
  localparam logic [STEP_BITS-1:0]    ACC_ZERO    = {STEP_BITS{1'b0}};

  typedef enum logic [1:0] {
    MODE_BOUNCE    = 2'd0,
    MODE_WRAP_UP   = 2'd1,
    MODE_WRAP_DOWN = 2'd2,
    MODE_HOLD      = 2'd3
  } mode_e;

  logic [PWM_DIV_BITS-1:0]            presc_r;
  logic [PWM_BITS-1:0]                ticker_r;
  logic [STEP_BITS-1:0]               acc_r;
  logic [POS_W-1:0]                   pos_r;
  logic [POS_W-1:0]                   pos_next_s;
  logic                               dir_up_r;
  logic                               dir_up_next_s;
  logic                               dir_eff_s;
  logic                               step_r;
  logic                               step_next_s;
  logic [NUM_LED-1:0]                 led_r;
  logic [NUM_LED-1:0]                 led_next_s;
  logic [NUM_LED-1:0][PWM_BITS-1:0]   level_r;
  logic [NUM_LED-1:0][PWM_BITS-1:0]   level_next_s;
  logic [3:0]                         rate_inc_s;
  logic [STEP_BITS:0]                 acc_sum_s;
  logic                               step_tick_s;
  mode_e                              mode_s;

`ifdef LED_SCANNER_FADE_EN
  localparam int LOW_W = STEP_BITS - PWM_BITS;
  localparam logic [PWM_BITS-1:0] LEVEL_ONE = PWM_BITS'(1'b1);
  logic [LOW_W:0] low_sum_s;
  logic           fade_tick_s;
`endif

  assign mode_s = mode_e'(mode);
  assign led    = led_r;
  assign pos    = pos_r;
  assign step   = step_r;

  // Rate accumulator: a carry out of the top bit is a scan step, out of the low bits a fade tick.
  always_comb begin
    rate_inc_s  = {1'b0, rate} + 4'd1;
    acc_sum_s   = {1'b0, acc_r} + (STEP_BITS+1)'(rate_inc_s);
    step_tick_s = en & acc_sum_s[STEP_BITS];
`ifdef LED_SCANNER_FADE_EN
    low_sum_s   = {1'b0, acc_r[LOW_W-1:0]} + (LOW_W+1)'(rate_inc_s);
    fade_tick_s = en & low_sum_s[LOW_W];
`endif
  end

  // Next position; entering bounce at an endpoint always turns the direction inward.
  always_comb begin
    pos_next_s    = pos_r;
    dir_up_next_s = dir_up_r;
    dir_eff_s     = dir_up_r;
    step_next_s   = 1'b0;
    if (step_tick_s) begin
      case (mode_s)
        MODE_BOUNCE: begin
          if (pos_r == POS_LAST) begin
            dir_eff_s = 1'b0;
          end else if (pos_r == POS_ZERO) begin
            dir_eff_s = 1'b1;
          end else begin
            dir_eff_s = dir_up_r;
          end
          if (dir_eff_s) begin
            pos_next_s    = pos_r + POS_ONE;
            dir_up_next_s = (pos_next_s != POS_LAST);
          end else begin
            pos_next_s    = pos_r - POS_ONE;
            dir_up_next_s = (pos_next_s == POS_ZERO);
          end
          step_next_s = 1'b1;
        end
        MODE_WRAP_UP: begin
          pos_next_s  = (pos_r == POS_LAST) ? POS_ZERO : pos_r + POS_ONE;
          step_next_s = 1'b1;
        end
        MODE_WRAP_DOWN: begin
          pos_next_s  = (pos_r == POS_ZERO) ? POS_LAST : pos_r - POS_ONE;
          step_next_s = 1'b1;
        end
        MODE_HOLD: begin
          step_next_s = 1'b0;
        end
        default: begin
          step_next_s = 1'b0;
        end
      endcase
    end else begin
      step_next_s = 1'b0;
    end
  end

  // Brightness per LED, keyed to the position being loaded so level and pos change together.
  always_comb begin
    for (int i = 0; i < NUM_LED; i++) begin
      if (POS_W'(i) == pos_next_s) begin
        level_next_s[i] = LEVEL_MAX;
`ifdef LED_SCANNER_FADE_EN
      end else if (fade_tick_s && (level_r[i] != LEVEL_ZERO)) begin
        level_next_s[i] = level_r[i] - LEVEL_ONE;
      end else begin
        level_next_s[i] = level_r[i];
      end
`else
      end else begin
        level_next_s[i] = LEVEL_ZERO;
      end
`endif
      led_next_s[i] = (ticker_r < level_r[i]);
    end
  end

  // PWM time base; keeps running while scanning is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r  <= PRESC_ZERO;
      ticker_r <= LEVEL_ZERO;
      led_r    <= {NUM_LED{1'b0}};
      level_r  <= {(NUM_LED*PWM_BITS){1'b0}};
    end else begin
      presc_r <= presc_r + PRESC_ONE;
      if (presc_r == PRESC_ZERO) begin
        ticker_r <= ticker_r + TICK_ONE;
      end
      led_r   <= led_next_s;
      level_r <= level_next_s;
    end
  end

  // Scan state: accumulator, position, direction and the step pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r    <= ACC_ZERO;
      pos_r    <= POS_ZERO;
      dir_up_r <= 1'b1;
      step_r   <= 1'b0;
    end else begin
      if (en) begin
        acc_r <= acc_sum_s[STEP_BITS-1:0];
      end
      pos_r    <= pos_next_s;
      dir_up_r <= dir_up_next_s;
      step_r   <= step_next_s;
    end
  end

endmodule

// File: tb/tb_led_scanner.sv
// Scoreboard bench for led_scanner: expected positions and step spacing are queued as
// stimulus is applied and compared whenever the DUT pulses step.
module tb_led_scanner;

  localparam int NUM_LED      = 4;
  localparam int PWM_BITS     = 3;
  localparam int PWM_DIV_BITS = 2;
  localparam int STEP_BITS    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [2:0] rate;
  logic [3:0] led;
  logic [1:0] pos;
  logic       step;

  typedef struct {
    logic [1:0] pos;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   en_cyc = 0;
  int   last_mark = 0;
  int   on_cnt;
  int   off_cnt;

  logic [1:0] seq_bounce [7] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
  logic [1:0] seq_down   [6] = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
  logic [1:0] seq_up     [4] = '{2'd0, 2'd1, 2'd2, 2'd3};

  led_scanner #(
    .NUM_LED(NUM_LED),
    .PWM_BITS(PWM_BITS),
    .PWM_DIV_BITS(PWM_DIV_BITS),
    .STEP_BITS(STEP_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .mode(mode),
    .rate(rate),
    .led(led),
    .pos(pos),
    .step(step)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_pos(input logic [1:0] p, input int gap);
    exp_t e;
    e.pos = p;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_val("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_step(input int limit);
    int n = 0;
    @(negedge clk);
    while (step !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_val("step_seen", 32'(step), 32'd1);
  endtask

  task automatic count_led(input int idx, input int n, output int on_c, output int off_c);
    on_c  = 0;
    off_c = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int j = 0; j < NUM_LED; j++) begin
        if (led[j] === 1'b1) begin
          if (j == idx) on_c++;
          else off_c++;
        end
      end
    end
  endtask

  // Additions performed by the accumulator: spacing between steps is measured in enabled cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) en_cyc <= 0;
    else if (en) en_cyc <= en_cyc + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      last_mark <= 0;
    end else if (step === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_step", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("step_pos", 32'(pos), 32'(mon_e.pos));
        if (mon_e.gap != 0) check_val("step_gap", 32'(en_cyc - last_mark), 32'(mon_e.gap));
      end
      last_mark <= en_cyc;
    end
  end

  initial begin
    rst  = 1'b1;
    en   = 1'b1;
    mode = 2'd0;
    rate = 3'd7;
    repeat (3) @(negedge clk);
    check_val("rst_led", 32'(led), 32'd0);
    check_val("rst_pos", 32'(pos), 32'd0);
    check_val("rst_step", 32'(step), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) push_pos(seq_bounce[i], 32);
    drain(300);

    mode = 2'd2;
    for (int i = 0; i < 6; i++) push_pos(seq_down[i], 32);
    drain(250);

    mode = 2'd1;
    for (int i = 0; i < 4; i++) push_pos(seq_up[i], 32);
    drain(180);

    mode = 2'd3;
    repeat (64) @(negedge clk);
    count_led(3, 32, on_cnt, off_cnt);
    check_val("hold_pwm_lit", 32'(on_cnt), 32'd28);
    check_val("hold_pwm_dark", 32'(off_cnt), 32'd0);
    check_val("hold_pos", 32'(pos), 32'd3);
    mode = 2'd0;
    push_pos(2'd2, 0);
    drain(80);

    repeat (10) @(negedge clk);
    en = 1'b0;
    check_val("pause_pos_start", 32'(pos), 32'd2);
    count_led(2, 32, on_cnt, off_cnt);
    check_val("pause_pwm", 32'(on_cnt), 32'd28);
    repeat (68) @(negedge clk);
    check_val("pause_pos_end", 32'(pos), 32'd2);
    en = 1'b1;
    push_pos(2'd1, 32);
    drain(60);

    push_pos(2'd0, 32);
    wait_step(60);
`ifdef LED_SCANNER_FADE_EN
    count_led(1, 24, on_cnt, off_cnt);
    check_val("fade_tail_lit", (on_cnt > 0) ? 32'd1 : 32'd0, 32'd1);
    repeat (5) @(negedge clk);
    check_val("fade_tail_dark", 32'(led[1]), 32'd0);
`else
    @(negedge clk);
    check_val("no_fade_off", 32'(led[1]), 32'd0);
`endif
    drain(5);

    push_pos(2'd1, 32);
    push_pos(2'd2, 32);
    push_pos(2'd3, 32);
    drain(130);
    repeat (5) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("midscan_rst_led", 32'(led), 32'd0);
    check_val("midscan_rst_pos", 32'(pos), 32'd0);
    check_val("midscan_rst_step", 32'(step), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_pos(2'd1, 32);
    drain(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
